// File: rtl/i2s_pkg.sv
// Shared types and elaboration-time helpers for the I2S transmitter.
package i2s_pkg;

  typedef enum logic [1:0] {
    I2S_FMT_PHILIPS = 2'd0,
    I2S_FMT_LJ      = 2'd1,
    I2S_FMT_RJ      = 2'd2
  } i2s_fmt_e;

  // bck toggles twice per bit, 2*slot_w bits per frame
  function automatic int unsigned acc_inc(input int unsigned sample_rate,
                                          input int unsigned slot_w);
    return 4 * sample_rate * slot_w;
  endfunction

  // Accumulator must hold (clk_hz - 1 + inc) before the subtract
  function automatic int unsigned acc_width(input int unsigned clk_hz,
                                            input int unsigned inc);
    return $clog2(clk_hz + inc);
  endfunction

  // The unused encoding 3 falls back to Philips framing
  function automatic i2s_fmt_e decode_fmt(input logic [1:0] f);
    i2s_fmt_e r;
    case (f)
      2'd1:    r = I2S_FMT_LJ;
      2'd2:    r = I2S_FMT_RJ;
      default: r = I2S_FMT_PHILIPS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Fractional (Bresenham) bit-clock generator; flags the clk cycle whose
// edge takes bck from 1 to 0.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 32000000,
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter int unsigned SLOT_W      = 16
) (
  input  logic clk,
  input  logic reset_n,
  output logic bck,
  output logic fall_tick
);

  localparam int unsigned INC = acc_inc(SAMPLE_RATE, SLOT_W);
  localparam int unsigned AW  = acc_width(CLK_HZ, INC);

  logic [AW-1:0] acc_q, acc_d, sum;
  logic          bck_q, bck_d, toggle;

  always_comb begin
    sum    = acc_q + AW'(INC);
    toggle = (sum >= AW'(CLK_HZ));
    acc_d  = toggle ? sum - AW'(CLK_HZ) : sum;
    bck_d  = bck_q ^ toggle;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      bck_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      bck_q <= bck_d;
    end
  end

  assign bck       = bck_q;
  // Combinational so the serializer registers update on the same edge as bck
  assign fall_tick = toggle & bck_q;

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S / left- / right-justified serializer with a one-pair holding
// register, valid/ready intake and sticky underrun flag.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 32000000,
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned SLOT_W      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          fmt,
  input  logic                mute,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                underrun_clr,
  output logic                underrun,
  output logic                frame_strobe,
  output logic                bck,
  output logic                ws,
  output logic                sdo
);

  localparam int unsigned     FW       = 2 * SLOT_W;
  localparam int unsigned     CW       = $clog2(FW);
  localparam logic [CW-1:0]   LAST_BIT = CW'(FW - 1);

  function automatic logic [SLOT_W-1:0] fmt_slot(input logic [SAMPLE_W-1:0] s,
                                                 input i2s_fmt_e f,
                                                 input logic m);
    logic [SLOT_W-1:0] slot;
    if (m)                    slot = '0;
    else if (f == I2S_FMT_RJ) slot = SLOT_W'($signed(s));
    else                      slot = SLOT_W'(s) << (SLOT_W - SAMPLE_W);
    return slot;
  endfunction

  logic                fall_tick, frame_start, accept, underrun_set;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]       shift_q, shift_d, frame;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [SAMPLE_W-1:0] prev_l_q, prev_l_d, prev_r_q, prev_r_d, pick_l, pick_r;
  logic                hold_full_q, hold_full_d;
  i2s_fmt_e            fmt_q, fmt_d;
  logic                ws_q, ws_d, sdo_q, sdo_d, last_bit_q, last_bit_d, stream;
  logic                frame_strobe_q, frame_strobe_d, underrun_q, underrun_d;

  i2s_clkgen #(
    .CLK_HZ      (CLK_HZ),
    .SAMPLE_RATE (SAMPLE_RATE),
    .SLOT_W      (SLOT_W)
  ) u_clkgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .bck       (bck),
    .fall_tick (fall_tick)
  );

  assign frame_start = fall_tick && (bit_cnt_q == LAST_BIT);
  assign accept      = sample_valid && !hold_full_q;

  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    hold_l_d       = hold_l_q;
    hold_r_d       = hold_r_q;
    hold_full_d    = hold_full_q;
    prev_l_d       = prev_l_q;
    prev_r_d       = prev_r_q;
    fmt_d          = fmt_q;
    ws_d           = ws_q;
    sdo_d          = sdo_q;
    last_bit_d     = last_bit_q;
    frame_strobe_d = 1'b0;
    underrun_set   = 1'b0;
    pick_l         = prev_l_q;
    pick_r         = prev_r_q;
    frame          = '0;
    stream         = 1'b0;

    if (accept) begin
      hold_l_d    = sample_l;
      hold_r_d    = sample_r;
      hold_full_d = 1'b1;
    end

    if (fall_tick) begin
      bit_cnt_d = frame_start ? '0 : bit_cnt_q + CW'(1);
      if (frame_start) begin
        fmt_d = decode_fmt(fmt);
        // An offer landing on an empty holding register in this very cycle
        // bypasses it, so the register stays empty afterwards
        if (hold_full_q) begin
          pick_l = hold_l_q;
          pick_r = hold_r_q;
        end else if (accept) begin
          pick_l = sample_l;
          pick_r = sample_r;
        end else begin
          underrun_set = 1'b1;
        end
        hold_full_d    = 1'b0;
        prev_l_d       = pick_l;
        prev_r_d       = pick_r;
        frame          = {fmt_slot(pick_l, fmt_d, mute), fmt_slot(pick_r, fmt_d, mute)};
        stream         = frame[FW-1];
        shift_d        = frame << 1;
        frame_strobe_d = 1'b1;
      end else begin
        stream  = shift_q[FW-1];
        shift_d = shift_q << 1;
      end
      ws_d       = (bit_cnt_d >= CW'(SLOT_W));
      sdo_d      = (fmt_d == I2S_FMT_PHILIPS) ? last_bit_q : stream;
      last_bit_d = stream;
    end

    underrun_d = underrun_set ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q      <= LAST_BIT;
      shift_q        <= '0;
      hold_l_q       <= '0;
      hold_r_q       <= '0;
      hold_full_q    <= 1'b0;
      prev_l_q       <= '0;
      prev_r_q       <= '0;
      fmt_q          <= I2S_FMT_PHILIPS;
      ws_q           <= 1'b0;
      sdo_q          <= 1'b0;
      last_bit_q     <= 1'b0;
      frame_strobe_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      hold_l_q       <= hold_l_d;
      hold_r_q       <= hold_r_d;
      hold_full_q    <= hold_full_d;
      prev_l_q       <= prev_l_d;
      prev_r_q       <= prev_r_d;
      fmt_q          <= fmt_d;
      ws_q           <= ws_d;
      sdo_q          <= sdo_d;
      last_bit_q     <= last_bit_d;
      frame_strobe_q <= frame_strobe_d;
      underrun_q     <= underrun_d;
    end
  end

  assign sample_ready = !hold_full_q;
  assign underrun     = underrun_q;
  assign frame_strobe = frame_strobe_q;
  assign ws           = ws_q;
  assign sdo          = sdo_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench: a 16-bit and a 12-bit sample instance, frames captured
// on bck rising edges and compared against a scoreboard of expected slots.
module tb_i2s_tx;

  localparam longint unsigned INC   = 64'd3072000;   // 4 * 48000 * 16
  localparam longint unsigned CLKHZ = 64'd32000000;

  logic        clk, reset_n;
  logic [1:0]  fmt;
  logic        mute;
  logic [15:0] smp_l, smp_r;
  logic        valid_a, valid_b, clr_a, clr_b;
  logic        ready_a, underrun_a, strobe_a, bck_a, ws_a, sdo_a;
  logic        ready_b, underrun_b, strobe_b, bck_b, ws_b, sdo_b;

  i2s_tx dut_a (
    .clk(clk), .reset_n(reset_n), .fmt(fmt), .mute(mute),
    .sample_l(smp_l), .sample_r(smp_r), .sample_valid(valid_a),
    .sample_ready(ready_a), .underrun_clr(clr_a), .underrun(underrun_a),
    .frame_strobe(strobe_a), .bck(bck_a), .ws(ws_a), .sdo(sdo_a)
  );

  i2s_tx #(.SAMPLE_W(12)) dut_b (
    .clk(clk), .reset_n(reset_n), .fmt(fmt), .mute(mute),
    .sample_l(smp_l[11:0]), .sample_r(smp_r[11:0]), .sample_valid(valid_b),
    .sample_ready(ready_b), .underrun_clr(clr_b), .underrun(underrun_b),
    .frame_strobe(strobe_b), .bck(bck_b), .ws(ws_b), .sdo(sdo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference bit-clock / bit-count model
  longint unsigned m_acc;
  logic            m_bck;
  int              m_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_acc <= 0; m_bck <= 1'b0; m_cnt <= 31;
    end else if (m_acc + INC >= CLKHZ) begin
      m_acc <= m_acc + INC - CLKHZ;
      m_bck <= ~m_bck;
      if (m_bck) m_cnt <= (m_cnt == 31) ? 0 : m_cnt + 1;
    end else begin
      m_acc <= m_acc + INC;
    end
  end

  function automatic logic pred_fs();
    return (m_acc + INC >= CLKHZ) && m_bck && (m_cnt == 31);
  endfunction

  typedef struct {
    int          sel;
    logic [1:0]  fmt;
    logic        mute;
    logic [15:0] l, r, exp_l, exp_r;
  } vec_t;

  typedef struct {
    int          sel;
    logic [1:0]  fmt;
    logic [15:0] exp_l, exp_r;
  } exp_t;

  vec_t vecs[10];
  exp_t sbq[$];
  logic prev_last[2];
  int   n_vec, n_err;
  bit   fs_pending;

  function automatic logic cur_bck(input int sel);    return sel != 0 ? bck_b    : bck_a;    endfunction
  function automatic logic cur_ws(input int sel);     return sel != 0 ? ws_b     : ws_a;     endfunction
  function automatic logic cur_sdo(input int sel);    return sel != 0 ? sdo_b    : sdo_a;    endfunction
  function automatic logic cur_ready(input int sel);  return sel != 0 ? ready_b  : ready_a;  endfunction
  function automatic logic cur_strobe(input int sel); return sel != 0 ? strobe_b : strobe_a; endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic drive(input int sel, input logic [1:0] f, input logic m,
                       input logic [15:0] l, input logic [15:0] r);
    int t = 0;
    while (!cur_ready(sel) && t < 2000) begin @(negedge clk); t++; end
    if (!cur_ready(sel)) timeout("drive ready");
    fmt = f; mute = m; smp_l = l; smp_r = r;
    if (sel != 0) valid_b = 1'b1; else valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0;
    fs_pending = cur_strobe(sel);
  endtask

  task automatic wait_strobe(input int sel);
    int t = 0;
    if (fs_pending) begin fs_pending = 1'b0; return; end
    do begin @(negedge clk); t++; end while (!cur_strobe(sel) && t < 2000);
    if (!cur_strobe(sel)) timeout("frame_strobe");
  endtask

  task automatic capture(input int sel, output logic [31:0] data, output logic [31:0] wsp);
    int   rises = 0, t = 0;
    logic prev, b;
    prev = cur_bck(sel); data = '0; wsp = '0;
    while (rises < 32 && t < 2000) begin
      @(negedge clk); t++;
      b = cur_bck(sel);
      if (b && !prev) begin
        data = {data[30:0], cur_sdo(sel)};
        wsp  = {wsp[30:0], cur_ws(sel)};
        rises++;
      end
      prev = b;
    end
    if (rises < 32) timeout("frame capture");
  endtask

  task automatic frame_check(input string name, input int sel);
    logic [31:0] data, wsp, stream, want;
    exp_t e;
    capture(sel, data, wsp);
    if (sbq.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e      = sbq.pop_front();
    stream = {e.exp_l, e.exp_r};
    want   = (e.fmt == 2'd1 || e.fmt == 2'd2) ? stream : {prev_last[e.sel], stream[31:1]};
    prev_last[e.sel] = stream[0];
    check({name, " data"}, data, want);
    check({name, " ws"}, wsp, 32'h0000FFFF);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " bck"},      {31'd0, bck_a},      32'd0);
    check({tag, " ws"},       {31'd0, ws_a},       32'd0);
    check({tag, " sdo"},      {31'd0, sdo_a},      32'd0);
    check({tag, " ready"},    {31'd0, ready_a},    32'd1);
    check({tag, " underrun"}, {31'd0, underrun_a}, 32'd0);
    check({tag, " strobe"},   {31'd0, strobe_a},   32'd0);
    check({tag, " b bck/ws"}, {30'd0, bck_b, ws_b}, 32'd0);
  endtask

  initial begin
    int toggles, rises, strobes, bck_bad, t, accepts, nstr;
    logic prev;
    n_vec = 0; n_err = 0; fs_pending = 1'b0;
    prev_last[0] = 1'b0; prev_last[1] = 1'b0;
    reset_n = 1'b0; fmt = 2'd1; mute = 1'b0; smp_l = '0; smp_r = '0;
    valid_a = 1'b0; valid_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;

    vecs[0] = '{0, 2'd1, 1'b0, 16'hA5C3, 16'h0F01, 16'hA5C3, 16'h0F01};
    vecs[1] = '{0, 2'd0, 1'b0, 16'hA5C3, 16'h0F01, 16'hA5C3, 16'h0F01};
    vecs[2] = '{0, 2'd2, 1'b0, 16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC};
    vecs[3] = '{0, 2'd3, 1'b0, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
    vecs[4] = '{0, 2'd1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[5] = '{0, 2'd1, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[6] = '{1, 2'd2, 1'b0, 16'h0800, 16'h07FF, 16'hF800, 16'h07FF};
    vecs[7] = '{1, 2'd1, 1'b0, 16'h0ABC, 16'h0123, 16'hABC0, 16'h1230};
    vecs[8] = '{1, 2'd0, 1'b0, 16'h05A5, 16'h0FFF, 16'h5A50, 16'hFFF0};
    vecs[9] = '{1, 2'd2, 1'b0, 16'h0ABC, 16'h0123, 16'hFABC, 16'h0123};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Rate: bck toggles, rises and frame strobes over 2000 clk
    toggles = 0; rises = 0; strobes = 0; bck_bad = 0; prev = 1'b0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (bck_a !== prev) toggles++;
      if (bck_a && !prev) rises++;
      if (strobe_a) strobes++;
      if (bck_a !== m_bck) bck_bad++;
      prev = bck_a;
      if (i == 125) check("toggles@125", toggles, 12);
    end
    check("toggles@2000", toggles, 192);
    check("rises@2000", rises, 96);
    check("strobes@2000", strobes, 3);
    check("bck vs model", bck_bad, 0);

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].sel, vecs[i].fmt, vecs[i].mute, vecs[i].l, vecs[i].r);
      sbq.push_back('{vecs[i].sel, vecs[i].fmt, vecs[i].exp_l, vecs[i].exp_r});
      wait_strobe(vecs[i].sel);
      frame_check($sformatf("vec%0d", i), vecs[i].sel);
    end

    // Underrun: missing sample repeats the pair; set beats a coincident clear
    clr_a = 1'b1; @(negedge clk); clr_a = 1'b0;
    check("underrun clear", {31'd0, underrun_a}, 32'd0);
    wait_strobe(0);
    check("underrun set", {31'd0, underrun_a}, 32'd1);
    sbq.push_back('{0, 2'd1, 16'h0000, 16'hFFFF});
    frame_check("underrun repeat", 0);
    clr_a = 1'b1; repeat (2) @(negedge clk);
    check("underrun clr held", {31'd0, underrun_a}, 32'd0);
    wait_strobe(0);
    check("set wins over clr", {31'd0, underrun_a}, 32'd1);
    clr_a = 1'b0;
    repeat (3) @(negedge clk);
    check("underrun sticky", {31'd0, underrun_a}, 32'd1);

    for (int i = 6; i < 10; i++) begin
      drive(vecs[i].sel, vecs[i].fmt, vecs[i].mute, vecs[i].l, vecs[i].r);
      sbq.push_back('{vecs[i].sel, vecs[i].fmt, vecs[i].exp_l, vecs[i].exp_r});
      wait_strobe(vecs[i].sel);
      frame_check($sformatf("vec%0d", i), vecs[i].sel);
    end

    // Forwarding: offer exactly in the frame-start cycle of an empty register
    clr_a = 1'b1; @(negedge clk);
    t = 0;
    while (!pred_fs() && t < 2000) begin @(negedge clk); t++; end
    if (!pred_fs()) timeout("forward window");
    clr_a = 1'b0; fmt = 2'd1; mute = 1'b0; smp_l = 16'h1357; smp_r = 16'h2468;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    check("fwd strobe", {31'd0, strobe_a}, 32'd1);
    check("fwd no underrun", {31'd0, underrun_a}, 32'd0);
    check("fwd ready", {31'd0, ready_a}, 32'd1);
    sbq.push_back('{0, 2'd1, 16'h1357, 16'h2468});
    frame_check("forward", 0);

    // Valid held high: one accept per frame
    wait_strobe(0);
    smp_l = 16'hFFFF; smp_r = 16'hFFFF; fmt = 2'd1; valid_a = 1'b1; clr_a = 1'b1;
    accepts = 0; nstr = 0; t = 0;
    if (ready_a) accepts++;
    @(negedge clk);
    clr_a = 1'b0;
    check("ready falls after accept", {31'd0, ready_a}, 32'd0);
    while (nstr < 3 && t < 5000) begin
      if (ready_a) accepts++;
      @(negedge clk); t++;
      if (strobe_a) nstr++;
    end
    valid_a = 1'b0;
    if (nstr < 3) timeout("held valid frames");
    check("accepts in 3 frames", accepts, 3);
    check("no underrun streaming", {31'd0, underrun_a}, 32'd0);

    // Asynchronous reset mid-frame with every output high
    t = 0;
    while (!(underrun_a && ws_a && bck_a && sdo_a) && t < 3000) begin @(negedge clk); t++; end
    if (!(underrun_a && ws_a && bck_a && sdo_a)) timeout("mid-frame state");
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
